// File: rtl/piece_dispatch_ctrl.sv
// Piece dispatch controller: fetches pieces from the generator queue, runs the
// spawn handshake, and manages the once-per-drop hold slot.
module piece_dispatch_ctrl #(
  parameter int GEN_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  next_piece,
  output logic        gen_advance,
  input  logic        hold_btn,
  input  logic        lock_evt,
  input  logic        top_out,
  output logic        spawn_valid,
  input  logic        spawn_ready,
  output logic [2:0]  spawn_piece,
  output logic        abort_piece,
  output logic [2:0]  hold_piece,
  output logic        hold_valid,
  output logic        hold_lock,
  output logic        game_over,
  output logic [15:0] piece_count
);

  typedef enum logic [2:0] {IDLE, FETCH, SPAWN, PLAY, OVER} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(GEN_LATENCY);

  state_t      state_reg, state_next;
  logic [3:0]  settle_reg, settle_next;
  logic [2:0]  active_reg, active_next;
  logic [2:0]  hold_piece_reg, hold_piece_next;
  logic        hold_valid_reg, hold_valid_next;
  logic        hold_lock_reg, hold_lock_next;
  logic [15:0] count_reg, count_next;
  logic        hold_d_reg;
  logic        spawn_valid_reg, gen_adv_reg, gen_adv_next, abort_reg, abort_next;
  logic        hold_edge;

  assign hold_edge = hold_btn & ~hold_d_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      settle_reg      <= '0;
      active_reg      <= '0;
      hold_piece_reg  <= '0;
      hold_valid_reg  <= 1'b0;
      hold_lock_reg   <= 1'b0;
      count_reg       <= '0;
      hold_d_reg      <= 1'b0;
      spawn_valid_reg <= 1'b0;
      gen_adv_reg     <= 1'b0;
      abort_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      settle_reg      <= settle_next;
      active_reg      <= active_next;
      hold_piece_reg  <= hold_piece_next;
      hold_valid_reg  <= hold_valid_next;
      hold_lock_reg   <= hold_lock_next;
      count_reg       <= count_next;
      hold_d_reg      <= hold_btn;
      // spawn_valid mirrors "now in SPAWN" but comes straight from a flop
      spawn_valid_reg <= (state_next == SPAWN);
      gen_adv_reg     <= gen_adv_next;
      abort_reg       <= abort_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    settle_next     = (settle_reg != 4'd0) ? settle_reg - 4'd1 : 4'd0;
    active_next     = active_reg;
    hold_piece_next = hold_piece_reg;
    hold_valid_next = hold_valid_reg;
    hold_lock_next  = hold_lock_reg;
    count_next      = count_reg;
    gen_adv_next    = 1'b0;
    abort_next      = 1'b0;

    case (state_reg)
      IDLE, OVER: begin
        if (start) begin
          state_next      = FETCH;
          hold_piece_next = '0;
          hold_valid_next = 1'b0;
          hold_lock_next  = 1'b0;
          count_next      = '0;
        end
      end
      FETCH: begin
        // settle guards against reading a stale head right after an advance
        if (settle_reg == 4'd0 && next_piece != 3'd0) begin
          active_next  = next_piece;
          gen_adv_next = 1'b1;
          settle_next  = SETTLE_LOAD;
          state_next   = SPAWN;
        end
      end
      SPAWN: begin
        if (top_out) begin
          state_next = OVER;
        end else if (spawn_valid_reg && spawn_ready) begin
          state_next = PLAY;
          if (count_reg != 16'hFFFF) count_next = count_reg + 16'd1;
        end
      end
      PLAY: begin
        if (lock_evt) begin
          hold_lock_next = 1'b0;
          state_next     = FETCH;
        end else if (hold_edge && !hold_lock_reg) begin
          hold_lock_next  = 1'b1;
          abort_next      = 1'b1;
          hold_piece_next = active_reg;
          if (hold_valid_reg) begin
            active_next = hold_piece_reg;
            state_next  = SPAWN;
          end else begin
            hold_valid_next = 1'b1;
            state_next      = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gen_advance = gen_adv_reg;
  assign spawn_valid = spawn_valid_reg;
  assign spawn_piece = active_reg;
  assign abort_piece = abort_reg;
  assign hold_piece  = hold_piece_reg;
  assign hold_valid  = hold_valid_reg;
  assign hold_lock   = hold_lock_reg;
  assign game_over   = (state_reg == OVER);
  assign piece_count = count_reg;

endmodule
